// File: rtl/iteration_sequencer.sv
// -----------------------------------------------------------------------------
// iteration_sequencer
//
// Run controller for the range-limited force pipeline. A run is a sequence of
// iterations; each one starts the broadcast controller, waits for every PE to
// issue its ref-particle force writeback, waits for the ring interconnect to
// drain, waits for the force path to go quiet, then hands off to the motion
// update and waits for it to finish.
//
// Parameters
//   NUM_CELLS     number of PEs / ring nodes (width of ref_wb_issued)
//   DRAIN_CYCLES  cycles after the last ref writeback before the ring is empty
//                 (must be >= 1)
//   ITER_WIDTH    width of iteration count and limit
//
// Ports
//   clk                  in   clock
//   rst_n                in   asynchronous active-low reset
//   start                in   run request, honoured in IDLE or DONE only
//   num_iters            in   iterations to run, sampled on accepted start
//   ref_wb_issued        in   per-PE pulse: ref force writeback issued
//   goto_next_ref        in   broadcast controller moving to next ref particle
//   all_reading_done     in   all PEs finished reading this iteration
//   force_path_idle      in   force write path fully quiesced
//   mu_done              in   motion update finished (pulse)
//   iter_start           out  pulse to broadcast controller
//   all_ref_wb_issued    out  every PE issued writeback for current ref
//   interconnect_empty   out  drain window elapsed
//   motion_update_start  out  pulse to motion update control
//   busy                 out  run in progress (FORCE or MU_WAIT)
//   sim_done             out  run finished (level)
//   iter_count           out  completed iterations in current run
// -----------------------------------------------------------------------------
module iteration_sequencer #(
  parameter int NUM_CELLS    = 64,
  parameter int DRAIN_CYCLES = NUM_CELLS,
  parameter int ITER_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iters,
  input  logic [NUM_CELLS-1:0]  ref_wb_issued,
  input  logic                  goto_next_ref,
  input  logic                  all_reading_done,
  input  logic                  force_path_idle,
  input  logic                  mu_done,
  output logic                  iter_start,
  output logic                  all_ref_wb_issued,
  output logic                  interconnect_empty,
  output logic                  motion_update_start,
  output logic                  busy,
  output logic                  sim_done,
  output logic [ITER_WIDTH-1:0] iter_count
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_MAX = CNT_W'(DRAIN_CYCLES);

  // Main FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FORCE   = 2'd1;
  localparam logic [1:0] S_MU_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Capture unit encoding
  localparam logic [0:0] C_COLLECT = 1'b0;
  localparam logic [0:0] C_DRAIN   = 1'b1;

  logic [1:0]            state_q, state_d;
  logic [ITER_WIDTH-1:0] limit_q, limit_d;
  logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
  logic                  sim_done_q, sim_done_d;
  logic                  iter_start_q, iter_start_d;
  logic                  mu_start_q, mu_start_d;
  logic                  busy_q, busy_d;

  logic [0:0]            cap_q, cap_d;
  logic [NUM_CELLS-1:0]  r_issued_q, r_issued_d;
  logic [NUM_CELLS-1:0]  r_collect;
  logic                  all_ref_q, all_ref_d;
  logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic                  ie_q, ie_d;

  // Sticky per-PE collection of writeback pulses
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_collect
      assign r_collect[gi] = r_issued_q[gi] | ref_wb_issued[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    iter_count_d = iter_count_q;
    sim_done_d   = sim_done_q;
    iter_start_d = 1'b0;
    mu_start_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          limit_d      = num_iters;
          iter_count_d = '0;
          if (num_iters == '0) begin
            // Empty run: finish immediately without touching the pipeline
            state_d    = S_DONE;
            sim_done_d = 1'b1;
          end else begin
            sim_done_d   = 1'b0;
            iter_start_d = 1'b1;
            state_d      = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        if (all_reading_done && force_path_idle && all_ref_q && ie_q) begin
          mu_start_d = 1'b1;
          state_d    = S_MU_WAIT;
        end
      end
      S_MU_WAIT: begin
        if (mu_done) begin
          iter_count_d = iter_count_q + ITER_WIDTH'(1);
          if (iter_count_d == limit_q) begin
            state_d    = S_DONE;
            sim_done_d = 1'b1;
          end else begin
            iter_start_d = 1'b1;
            state_d      = S_FORCE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FORCE) || (state_d == S_MU_WAIT);
  end

  // ---------------------------------------------------------------------------
  // Capture unit: live only while staying in FORCE, so leaving FORCE (the
  // motion_update_start edge) clears the flags in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_d       = cap_q;
    r_issued_d  = r_issued_q;
    all_ref_d   = all_ref_q;
    drain_cnt_d = drain_cnt_q;
    ie_d        = ie_q;
    if ((state_q != S_FORCE) || (state_d != S_FORCE)) begin
      cap_d       = C_COLLECT;
      r_issued_d  = '0;
      all_ref_d   = 1'b0;
      drain_cnt_d = '0;
      ie_d        = 1'b0;
    end else begin
      case (cap_q)
        C_COLLECT: begin
          r_issued_d = r_collect;
          // Act on the registered set, so a goto_next_ref arriving with the
          // final pulse cannot pre-empt the capture.
          if (&r_issued_q) begin
            all_ref_d   = 1'b1;
            drain_cnt_d = '0;
            ie_d        = 1'b0;
            cap_d       = C_DRAIN;
          end
        end
        default: begin
          if (goto_next_ref) begin
            // Next ref particle: restart collection even if drain completed
            cap_d       = C_COLLECT;
            r_issued_d  = '0;
            all_ref_d   = 1'b0;
            drain_cnt_d = '0;
            ie_d        = 1'b0;
          end else begin
            if (drain_cnt_q != DRAIN_MAX) begin
              drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
            ie_d = (drain_cnt_d == DRAIN_MAX);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      limit_q      <= '0;
      iter_count_q <= '0;
      sim_done_q   <= 1'b0;
      iter_start_q <= 1'b0;
      mu_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      cap_q        <= C_COLLECT;
      r_issued_q   <= '0;
      all_ref_q    <= 1'b0;
      drain_cnt_q  <= '0;
      ie_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      iter_count_q <= iter_count_d;
      sim_done_q   <= sim_done_d;
      iter_start_q <= iter_start_d;
      mu_start_q   <= mu_start_d;
      busy_q       <= busy_d;
      cap_q        <= cap_d;
      r_issued_q   <= r_issued_d;
      all_ref_q    <= all_ref_d;
      drain_cnt_q  <= drain_cnt_d;
      ie_q         <= ie_d;
    end
  end

  assign iter_start          = iter_start_q;
  assign all_ref_wb_issued   = all_ref_q;
  assign interconnect_empty  = ie_q;
  assign motion_update_start = mu_start_q;
  assign busy                = busy_q;
  assign sim_done            = sim_done_q;
  assign iter_count          = iter_count_q;

endmodule

// File: doc/iteration_sequencer.md
# iteration_sequencer

Top-level run controller for the range-limited force pipeline. It issues per-iteration start pulses to the broadcast controller, collects per-PE `ref_wb_issued` pulses, and times the ring-interconnect drain window. It gates the motion-update start on a fully quiesced force path, counts completed iterations, and flags simulation completion. It sits beside the broadcast controller and drives `iter_start`, `all_ref_wb_issued` and `motion_update_start`.

## Interface
- `NUM_CELLS`, 64: number of PEs / ring nodes; width of `ref_wb_issued`.
- `DRAIN_CYCLES`, NUM_CELLS: cycles to wait after the last ref writeback before the ring counts as empty; must be ≥1.
- `ITER_WIDTH`, 16: width of the iteration count and limit.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle run request; honoured only in IDLE or DONE.
- `num_iters` in ITER_WIDTH: number of iterations to run; sampled on an accepted `start`.
- `ref_wb_issued` in NUM_CELLS: per-PE pulse, "this ref particle's force writeback issued".
- `goto_next_ref` in 1: broadcast controller advancing to the next ref particle.
- `all_reading_done` in 1: all PEs finished reading for this iteration.
- `force_path_idle` in 1: no force write enables, force cache input buffers empty, filter buffers empty.
- `mu_done` in 1: motion update finished (single-cycle pulse).
- `iter_start` out 1: single-cycle pulse to the broadcast controller.
- `all_ref_wb_issued` out 1: every PE has issued writeback for the current ref.
- `interconnect_empty` out 1: drain window elapsed since `all_ref_wb_issued` rose.
- `motion_update_start` out 1: single-cycle pulse to motion_update_control.
- `busy` out 1: run in progress (state is not IDLE or DONE).
- `sim_done` out 1: run finished; level signal.
- `iter_count` out ITER_WIDTH: completed iterations in the current run.

## Operation
- All outputs are registered and reset to 0. All state clears asynchronously on `rst_n` low, including in the middle of a run.
- Main FSM states: IDLE, FORCE, MU_WAIT, DONE.
  - IDLE or DONE, on `start`:
    - Latch `num_iters` as `limit`, clear `iter_count`, clear `sim_done`.
    - If `limit` == 0, go to DONE and set `sim_done`; no `iter_start` is issued.
    - Otherwise pulse `iter_start` and go to FORCE.
  - FORCE: when `all_reading_done & force_path_idle & all_ref_wb_issued & interconnect_empty` holds, pulse `motion_update_start`, clear the capture unit, and go to MU_WAIT.
  - MU_WAIT, on `mu_done`:
    - Increment `iter_count`.
    - If the new count == `limit`, go to DONE and set `sim_done`.
    - Otherwise pulse `iter_start` and go to FORCE.
  - `start` is ignored in FORCE and MU_WAIT. `mu_done` is ignored outside MU_WAIT.
- Capture unit (active only in FORCE; held clear in all other states):
  - COLLECT: `r_issued[k]` |= `ref_wb_issued[k]`. When `&r_issued`, set `all_ref_wb_issued`, zero `drain_cnt`, go to DRAIN.
  - DRAIN: `drain_cnt` increments and saturates at DRAIN_CYCLES. `interconnect_empty` = (`drain_cnt` == DRAIN_CYCLES).
  - In DRAIN, `goto_next_ref` clears `r_issued`, `all_ref_wb_issued`, `drain_cnt` and `interconnect_empty`, and returns to COLLECT. This takes effect whether or not the drain has elapsed.
  - In DRAIN, `ref_wb_issued` pulses are ignored.
- `iter_count` wraps modulo 2^ITER_WIDTH. Since `limit` < 2^ITER_WIDTH, wrap is unreachable in normal use.

## Timing
- `start` accepted at edge t: `iter_start` and `busy` are high in cycle t+1. `iter_start` is a 1-cycle pulse.
- Last missing `ref_wb_issued` bit sampled at edge t:
  - `r_issued` is full after edge t.
  - `all_ref_wb_issued` rises after edge t+1.
  - `interconnect_empty` rises DRAIN_CYCLES edges later and then holds.
- Gating condition true at edge t: `motion_update_start` is high for cycle t+1 only. Capture outputs fall at the same edge.
- `mu_done` at edge t:
  - `iter_count` updates after edge t.
  - Either `iter_start` or `sim_done` is high in cycle t+1.
- Simultaneous events:
  - `ref_wb_issued` completing `&r_issued` together with `goto_next_ref` while in COLLECT: the capture wins and DRAIN is entered.
  - `goto_next_ref` together with drain completion: the clear wins.

## Test plan
- Reset mid-DRAIN with `drain_cnt`=10: all outputs 0 immediately; after `rst_n` release, state is IDLE and `busy`=0.
- `num_iters`=0, `start`: `sim_done`=1 next cycle, no `iter_start`, `busy` stays 0.
- NUM_CELLS=4, DRAIN_CYCLES=4, staggered `ref_wb_issued` at cycles 3,5,5,9:
  - `all_ref_wb_issued` rises at cycle 11.
  - `interconnect_empty` rises at cycle 15.
  - With the other gates high, `motion_update_start` pulses at cycle 16.
- `goto_next_ref` at drain count 2: flags clear, collection restarts, and no `motion_update_start` pulse occurs.
- `num_iters`=3 with `mu_done` returned 20 cycles after each `motion_update_start`:
  - Exactly 3 `iter_start` pulses and 3 `motion_update_start` pulses.
  - Final `iter_count`=3 and `sim_done`=1.
- `start` asserted in FORCE: ignored, `limit` unchanged. `start` asserted in DONE: starts a new run and clears `sim_done`.
